position_filter: RTL

POSITION_FILTER -- requirements
Module: position_filter

---
 rtl/position_filter_if.sv | 22 ++
 rtl/position_filter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/position_filter_if.sv
// Frame-rate centroid bus between the colour-detection stage and the position filter.
// The producer drives vsync and the centroid; the filter returns averages and status.
interface position_filter_if;
  logic               vsync_in;
  logic signed [31:0] x_in;
  logic signed [31:0] y_in;
  logic [9:0]         x_avg;
  logic [9:0]         y_avg;
  logic               pos_valid;
  logic               track_lost;
  logic               flap;

  modport master (
    output vsync_in, x_in, y_in,
    input  x_avg, y_avg, pos_valid, track_lost, flap
  );

  modport slave (
    input  vsync_in, x_in, y_in,
    output x_avg, y_avg, pos_valid, track_lost, flap
  );
endinterface

// File: rtl/position_filter.sv
// Per-frame centroid averaging over a DEPTH-frame ring, track-loss detection and
// flap detection on fast upward motion of the averaged y position.
//
// state  | meaning
// IDLE   | wait for a synchronized vsync rising edge
// SAMPLE | capture and range-check the centroid
// UPDATE | push the sample into the ring or count a miss (flush on loss)
// DECIDE | register averages, status flags and the flap pulse
module position_filter #(
  parameter int DEPTH       = 4,
  parameter int X_MAX       = 320,
  parameter int Y_MAX       = 240,
  parameter int LOST_FRAMES = 8,
  parameter int FLAP_DELTA  = 12,
  parameter int COOLDOWN    = 3
) (
  input logic               clk,
  input logic               reset,
  position_filter_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int SUM_W  = 10 + AW;
  localparam int CNT_W  = AW + 1;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
  localparam logic [MISS_W-1:0] LOST    = MISS_W'(LOST_FRAMES);
  localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [9:0]        FLAP_D  = 10'(FLAP_DELTA);

  typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, DECIDE} state_t;

  state_t             state;
  logic [2:0]         vs_sync;
  logic               frame_evt;
  logic [9:0]         smp_x, smp_y;
  logic               smp_ok;
  logic [9:0]         ring_x [DEPTH];
  logic [9:0]         ring_y [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [SUM_W-1:0]   sum_x, sum_y;
  logic [MISS_W-1:0]  miss;
  logic [CD_W-1:0]    cooldown;

  logic               sample_ok;
  logic [9:0]         evict_x, evict_y;
  logic [MISS_W-1:0]  miss_inc;
  logic [9:0]         y_new;
  logic               window_full;
  logic               flap_ok;

  // vs_sync[1] is the synchronized vsync, vs_sync[2] its previous value
  assign frame_evt = vs_sync[1] & ~vs_sync[2];

  always_comb begin
    sample_ok   = (bus.x_in >= 0) && (bus.x_in < X_MAX) &&
                  (bus.y_in >= 0) && (bus.y_in < Y_MAX);
    window_full = (count == FULL);
    evict_x     = window_full ? ring_x[wr_ptr] : '0;
    evict_y     = window_full ? ring_y[wr_ptr] : '0;
    miss_inc    = (miss == LOST) ? miss : miss + 1'b1;
    y_new       = sum_y[AW +: 10];
    // unsigned step: only an upward move (y shrinking) can qualify
    flap_ok     = bus.pos_valid && window_full && (bus.y_avg >= y_new) &&
                  ((bus.y_avg - y_new) >= FLAP_D) && (cooldown == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      vs_sync        <= '0;
      smp_x          <= '0;
      smp_y          <= '0;
      smp_ok         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_x[i] <= '0;
        ring_y[i] <= '0;
      end
      wr_ptr         <= '0;
      count          <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      miss           <= '0;
      cooldown       <= '0;
      bus.x_avg      <= '0;
      bus.y_avg      <= '0;
      bus.pos_valid  <= 1'b0;
      bus.track_lost <= 1'b0;
      bus.flap       <= 1'b0;
    end else begin
      vs_sync  <= {vs_sync[1:0], bus.vsync_in};
      bus.flap <= 1'b0;
      case (state)
        IDLE: if (frame_evt) state <= SAMPLE;
        SAMPLE: begin
          smp_x  <= bus.x_in[9:0];
          smp_y  <= bus.y_in[9:0];
          smp_ok <= sample_ok;
          state  <= UPDATE;
        end
        UPDATE: begin
          if (smp_ok) begin
            ring_x[wr_ptr] <= smp_x;
            ring_y[wr_ptr] <= smp_y;
            wr_ptr         <= wr_ptr + 1'b1;
            sum_x          <= sum_x + SUM_W'(smp_x) - SUM_W'(evict_x);
            sum_y          <= sum_y + SUM_W'(smp_y) - SUM_W'(evict_y);
            count          <= window_full ? count : count + 1'b1;
            miss           <= '0;
          end else begin
            miss <= miss_inc;
            if (miss_inc == LOST) begin
              count    <= '0;
              sum_x    <= '0;
              sum_y    <= '0;
              wr_ptr   <= '0;
              cooldown <= '0;
            end
          end
          state <= DECIDE;
        end
        DECIDE: begin
          if (window_full) begin
            bus.x_avg <= sum_x[AW +: 10];
            bus.y_avg <= y_new;
          end
          bus.pos_valid  <= window_full;
          bus.track_lost <= (miss == LOST);
          bus.flap       <= flap_ok;
          if (flap_ok)               cooldown <= CD_LOAD;
          else if (cooldown != '0)   cooldown <= cooldown - 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
